timer_control: RTL and testbench

Sequencing controller for the CPU's divider/gamma timer and the HALT low-power state. It sits between instruction decode, the key-input matrix and the divider block. It merges clear requests from several sources into single reset pulses, runs the HALT/wake state machine, and qualifies key wake-ups against the divider's 1 kHz tap.

---
 rtl/timer_pkg.sv | 21 ++
 rtl/timer_control_key_wake_filter.sv | 44 ++++
 rtl/timer_control.sv | 101 ++++++++++
 tb/tb_timer_control.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the timer/HALT sequencing controller.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_WAKE   = 2'd2
  } state_e;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_TIMER = 2'd1;
  localparam logic [1:0] CAUSE_KEY   = 2'd2;
  localparam logic [1:0] CAUSE_BOTH  = 2'd3;

  localparam logic [3:0] CPU_SM5A = 4'd4;

  function automatic logic [1:0] encode_cause(input logic timer_hit, input logic key_hit);
    return {key_hit, timer_hit};
  endfunction

endpackage

// File: rtl/timer_control_key_wake_filter.sv
// Key wake qualifier: counts 1 kHz rising edges while a key is held during HALT.
module key_wake_filter #(
  parameter int KEY_FILTER = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clk_en,
  input  logic enable,
  input  logic clear,
  input  logic key_active,
  input  logic divider_1khz,
  output logic key_wake
);

  localparam logic [3:0] LIMIT = 4'(KEY_FILTER);

  logic       khz_prev_q, khz_prev_d;
  logic [3:0] count_q, count_d;
  logic       khz_rise;

  // key_wake looks at the next count so the qualifying edge acts in the same cycle as a timer tick
  always_comb begin
    khz_rise   = divider_1khz && !khz_prev_q;
    khz_prev_d = divider_1khz;
    count_d    = count_q;
    if (clear || !key_active) begin
      count_d = 4'd0;
    end else if (enable && khz_rise && (count_q < LIMIT)) begin
      count_d = count_q + 4'd1;
    end
    key_wake = enable && key_active && (count_d == LIMIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      khz_prev_q <= 1'b0;
      count_q    <= 4'd0;
    end else if (clk_en) begin
      khz_prev_q <= khz_prev_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: rtl/timer_control.sv
// HALT/wake sequencer and divider/gamma clear-pulse merger between decode, key matrix and divider.
module timer_control
  import timer_pkg::*;
#(
  parameter int KEY_FILTER = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_en,
  input  logic [3:0] cpu_id,
  input  logic       idiv_req,
  input  logic       gamma_clr_req,
  input  logic       halt_req,
  input  logic       key_active,
  input  logic       gamma,
  input  logic       divider_1s_tick,
  input  logic       divider_1khz,
  output logic       reset_gamma,
  output logic       reset_divider,
  output logic       halted,
  output logic       wake,
  output logic [1:0] wake_cause
);

  state_e     state_q, state_d;
  logic       reset_gamma_q, reset_gamma_d;
  logic       reset_divider_q, reset_divider_d;
  logic [1:0] cause_q, cause_d;
  logic       gamma_at_halt_q, gamma_at_halt_d;
  logic       filter_clear;
  logic       timer_wake;
  logic       key_wake;

  key_wake_filter #(.KEY_FILTER(KEY_FILTER)) u_key_filter (
    .clk          (clk),
    .reset_n      (reset_n),
    .clk_en       (clk_en),
    .enable       (state_q == ST_HALTED),
    .clear        (filter_clear),
    .key_active   (key_active),
    .divider_1khz (divider_1khz),
    .key_wake     (key_wake)
  );

  // Clear pulses default low so each request yields exactly one clk_en-cycle pulse
  always_comb begin
    state_d         = state_q;
    reset_gamma_d   = 1'b0;
    reset_divider_d = 1'b0;
    cause_d         = cause_q;
    gamma_at_halt_d = gamma_at_halt_q;
    filter_clear    = 1'b0;
    timer_wake      = divider_1s_tick || gamma_at_halt_q;
    case (state_q)
      ST_RUN: begin
        reset_divider_d = idiv_req;
        reset_gamma_d   = gamma_clr_req;
        if (halt_req) begin
          state_d         = ST_HALTED;
          filter_clear    = 1'b1;
          gamma_at_halt_d = gamma && (cpu_id != CPU_SM5A);
        end
      end
      ST_HALTED: begin
        if (timer_wake || key_wake) begin
          state_d       = ST_WAKE;
          cause_d       = encode_cause(timer_wake, key_wake);
          reset_gamma_d = timer_wake && (cpu_id == CPU_SM5A);
        end
      end
      ST_WAKE: begin
        state_d         = ST_RUN;
        gamma_at_halt_d = 1'b0;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_RUN;
      reset_gamma_q   <= 1'b0;
      reset_divider_q <= 1'b0;
      cause_q         <= CAUSE_NONE;
      gamma_at_halt_q <= 1'b0;
    end else if (clk_en) begin
      state_q         <= state_d;
      reset_gamma_q   <= reset_gamma_d;
      reset_divider_q <= reset_divider_d;
      cause_q         <= cause_d;
      gamma_at_halt_q <= gamma_at_halt_d;
    end
  end

  assign reset_gamma   = reset_gamma_q;
  assign reset_divider = reset_divider_q;
  assign halted        = (state_q == ST_HALTED);
  assign wake          = (state_q == ST_WAKE);
  assign wake_cause    = cause_q;

endmodule

// File: tb/tb_timer_control.sv
// Scoreboard bench for timer_control: stimulus queues expected outputs, a monitor compares after each edge.
module tb_timer_control;

  typedef struct {
    string      name;
    logic [5:0] val;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       clk_en;
  logic [3:0] cpu_id;
  logic       idiv_req, gamma_clr_req, halt_req, key_active, gamma;
  logic       divider_1s_tick, divider_1khz;
  logic       reset_gamma, reset_divider, halted, wake;
  logic [1:0] wake_cause;

  exp_t expQ[$];
  int   testsRun  = 0;
  int   testsFail = 0;

  timer_control #(.KEY_FILTER(2)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .clk_en          (clk_en),
    .cpu_id          (cpu_id),
    .idiv_req        (idiv_req),
    .gamma_clr_req   (gamma_clr_req),
    .halt_req        (halt_req),
    .key_active      (key_active),
    .gamma           (gamma),
    .divider_1s_tick (divider_1s_tick),
    .divider_1khz    (divider_1khz),
    .reset_gamma     (reset_gamma),
    .reset_divider   (reset_divider),
    .halted          (halted),
    .wake            (wake),
    .wake_cause      (wake_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {reset_gamma, reset_divider, halted, wake, wake_cause}
  function automatic logic [5:0] outVec();
    return {reset_gamma, reset_divider, halted, wake, wake_cause};
  endfunction

  task automatic checkOutput(input string name, input logic [5:0] got, input logic [5:0] expv);
    testsRun++;
    if (got !== expv) begin
      testsFail++;
      $display("[TB] FAIL %s: got rg/rd/hlt/wk/cause=%b required %b", name, got, expv);
    end
  endtask

  task automatic clearInputs();
    clk_en          = 1'b1;
    idiv_req        = 1'b0;
    gamma_clr_req   = 1'b0;
    halt_req        = 1'b0;
    key_active      = 1'b0;
    gamma           = 1'b0;
    divider_1s_tick = 1'b0;
    divider_1khz    = 1'b0;
  endtask

  // Drive one cycle of inputs at the falling edge and queue the outputs expected after the next rising edge
  task automatic applyStimulus(input string name, input logic ce, input logic idiv, input logic gclr,
                               input logic halt, input logic key, input logic gam, input logic tick,
                               input logic khz, input logic [5:0] expv);
    exp_t e;
    @(negedge clk);
    clk_en          = ce;
    idiv_req        = idiv;
    gamma_clr_req   = gclr;
    halt_req        = halt;
    key_active      = key;
    gamma           = gam;
    divider_1s_tick = tick;
    divider_1khz    = khz;
    e.name = name;
    e.val  = expv;
    expQ.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e.name, outVec(), e.val);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    clearInputs();
    cpu_id  = 4'd0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1 checkOutput("reset_state", outVec(), 6'b000000);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    //                 name          ce id gc ha ky ga tk kz  rg rd hl wk cause
    applyStimulus("idle",          1, 0, 0, 0, 0, 0, 0, 0, 6'b000000);
    applyStimulus("idiv_pulse",    1, 1, 0, 0, 0, 0, 0, 0, 6'b010000);
    applyStimulus("idiv_release",  1, 0, 0, 0, 0, 0, 0, 0, 6'b000000);
    applyStimulus("idiv_gclr",     1, 1, 1, 0, 0, 0, 0, 0, 6'b110000);
    applyStimulus("gclr_b2b_1",    1, 0, 1, 0, 0, 0, 0, 0, 6'b100000);
    applyStimulus("gclr_b2b_2",    1, 0, 1, 0, 0, 0, 0, 0, 6'b100000);
    applyStimulus("gclr_release",  1, 0, 0, 0, 0, 0, 0, 0, 6'b000000);
    applyStimulus("ce_idiv",       1, 1, 0, 0, 0, 0, 0, 0, 6'b010000);
    applyStimulus("ce_low_hold",   0, 0, 0, 0, 0, 0, 0, 0, 6'b010000);
    applyStimulus("ce_low_ignore", 0, 1, 1, 0, 0, 0, 0, 0, 6'b010000);
    applyStimulus("ce_high_clear", 1, 0, 0, 0, 0, 0, 0, 0, 6'b000000);
    applyStimulus("halt_idiv",     1, 1, 0, 1, 0, 0, 0, 0, 6'b011000);
    applyStimulus("halted_ignore", 1, 1, 1, 1, 0, 0, 0, 0, 6'b001000);
    applyStimulus("halted_wait",   1, 0, 0, 0, 0, 0, 0, 0, 6'b001000);
    applyStimulus("timer_wake",    1, 0, 0, 0, 0, 0, 1, 0, 6'b000101);
    applyStimulus("back_to_run",   1, 0, 0, 0, 0, 0, 0, 0, 6'b000001);

    cpu_id = 4'd4;
    applyStimulus("sm5a_halt",     1, 0, 0, 1, 0, 0, 0, 0, 6'b001001);
    applyStimulus("sm5a_wake",     1, 0, 0, 0, 0, 0, 1, 0, 6'b100101);
    applyStimulus("sm5a_run",      1, 0, 0, 0, 0, 0, 0, 0, 6'b000001);

    cpu_id = 4'd0;
    applyStimulus("gam_halt",      1, 0, 0, 1, 0, 1, 0, 0, 6'b001001);
    applyStimulus("gam_wake",      1, 0, 0, 0, 0, 0, 0, 0, 6'b000101);
    applyStimulus("gam_run",       1, 0, 0, 0, 0, 0, 0, 0, 6'b000001);

    applyStimulus("key_halt",      1, 0, 0, 1, 0, 0, 0, 0, 6'b001001);
    applyStimulus("key_rise1",     1, 0, 0, 0, 1, 0, 0, 1, 6'b001001);
    applyStimulus("key_low1",      1, 0, 0, 0, 1, 0, 0, 0, 6'b001001);
    applyStimulus("key_rise2",     1, 0, 0, 0, 1, 0, 0, 1, 6'b000110);
    applyStimulus("key_run",       1, 0, 0, 0, 0, 0, 0, 0, 6'b000010);

    applyStimulus("drop_halt",     1, 0, 0, 1, 0, 0, 0, 0, 6'b001010);
    applyStimulus("drop_rise1",    1, 0, 0, 0, 1, 0, 0, 1, 6'b001010);
    applyStimulus("drop_release",  1, 0, 0, 0, 0, 0, 0, 0, 6'b001010);
    applyStimulus("drop_rise1b",   1, 0, 0, 0, 1, 0, 0, 1, 6'b001010);
    applyStimulus("drop_low",      1, 0, 0, 0, 1, 0, 0, 0, 6'b001010);
    applyStimulus("drop_rise_nok", 1, 0, 0, 0, 0, 0, 0, 1, 6'b001010);
    applyStimulus("both_low",      1, 0, 0, 0, 1, 0, 0, 0, 6'b001010);
    applyStimulus("both_rise1",    1, 0, 0, 0, 1, 0, 0, 1, 6'b001010);
    applyStimulus("both_low2",     1, 0, 0, 0, 1, 0, 0, 0, 6'b001010);
    applyStimulus("both_wake",     1, 0, 0, 0, 1, 0, 1, 1, 6'b000111);
    applyStimulus("both_run",      1, 0, 0, 0, 0, 0, 0, 0, 6'b000011);

    applyStimulus("rst_halt_idiv", 1, 1, 0, 1, 0, 0, 0, 0, 6'b011011);
    @(negedge clk);
    #1 reset_n = 1'b0;
    clearInputs();
    #1 checkOutput("async_reset", outVec(), 6'b000000);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus("post_rst_idle", 1, 0, 0, 0, 0, 0, 0, 0, 6'b000000);
    applyStimulus("post_rst_tick", 1, 0, 0, 0, 0, 0, 1, 0, 6'b000000);

    @(negedge clk);
    clearInputs();
    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge clk);
    #4;
    testsRun++;
    if (expQ.size() != 0) begin
      testsFail++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
